addsub_pipe: RTL and testbench

Parametrised, pipelined two's-complement add/subtract unit with valid/ready handshaking, carry/borrow-in, overflow detection and optional signed saturation. The carry chain is split into CHUNK-bit slices, with one register stage per slice. This lets wide operands close timing at full clock rate. It is the datapath arithmetic element feeding the ALU result mux and the accumulator blocks.

---
 rtl/addsub_pkg.sv | 33 +++
 rtl/addsub_if.sv | 27 ++
 rtl/addsub_chunk.sv | 16 +
 rtl/addsub_pipe.sv | 90 +++++++++
 tb/tb_addsub_pipe.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the pipelined add/subtract unit.
// Latency n/a (types only); backpressure n/a.
package addsub_pkg;

  localparam int MAX_WIDTH = 256;

  typedef struct packed {
    logic vld;
    logic sel;
    logic sat;
    logic cry;
    logic cmsb;
  } stage_ctl_t;

  function automatic int stages_f(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] smax_f(input int width);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < width - 1; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] smin_f(input int width);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/addsub_if.sv
// Operand/result handshake bundle for addsub_pipe.
// Latency n/a; valid/ready in both directions.
interface addsub_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sel;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             over_flow;
  logic             zero;

  modport master (
    output in_valid, a, b, c_in, sel, sat, out_ready,
    input  in_ready, out_valid, sum, c_out, over_flow, zero
  );

  modport slave (
    input  in_valid, a, b, c_in, sel, sat, out_ready,
    output in_ready, out_valid, sum, c_out, over_flow, zero
  );
endinterface

// File: rtl/addsub_chunk.sv
// One CHUNK-bit ripple slice of the carry chain; purely combinational.
// Latency 0; no backpressure.
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  // Carry into the top bit recovered from its sum bit.
  assign c_msb_in  = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];
endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract with carry/borrow-in, overflow and optional saturation.
// Latency STAGES cycles, 1 beat/cycle; whole pipe freezes when output stalls.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  addsub_if.slave  bus
);
  localparam int STAGES = stages_f(WIDTH, CHUNK);
  localparam int LAST   = STAGES - 1;
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(smax_f(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(smin_f(WIDTH));

  stage_ctl_t       ctl_q   [STAGES];
  stage_ctl_t       ctl_src [STAGES];
  logic [WIDTH-1:0] res_q   [STAGES];
  logic [WIDTH-1:0] res_src [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] a_src   [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] b_src   [STAGES];
  logic [CHUNK-1:0] ch_s    [STAGES];
  logic             ch_co   [STAGES];
  logic             ch_cm   [STAGES];

  logic             adv;
  logic             out_vld;
  logic             ovf;
  logic             pos_ovf;
  logic [WIDTH-1:0] sum_sat;

  // Slice k takes its operands from the input (k=0) or the previous stage record.
  always_comb begin
    ctl_src[0] = '{vld: bus.in_valid, sel: bus.sel, sat: bus.sat,
                   cry: bus.c_in ^ bus.sel, cmsb: 1'b0};
    a_src[0]   = bus.a;
    b_src[0]   = bus.b ^ {WIDTH{bus.sel}};
    res_src[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      ctl_src[k] = ctl_q[k-1];
      a_src[k]   = a_q[k-1];
      b_src[k]   = b_q[k-1];
      res_src[k] = res_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a        (a_src[k][k*CHUNK +: CHUNK]),
      .b        (b_src[k][k*CHUNK +: CHUNK]),
      .cin      (ctl_src[k].cry),
      .s        (ch_s[k]),
      .cout     (ch_co[k]),
      .c_msb_in (ch_cm[k])
    );
  end

  // Data fields carry no reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) ctl_q[k].vld <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        ctl_q[k] <= '{vld: ctl_src[k].vld, sel: ctl_src[k].sel, sat: ctl_src[k].sat,
                      cry: ch_co[k], cmsb: ch_cm[k]};
        a_q[k]   <= a_src[k];
        b_q[k]   <= b_src[k];
        res_q[k] <= res_src[k] | (WIDTH'(ch_s[k]) << (k * CHUNK));
      end
    end
  end

  assign out_vld = ctl_q[LAST].vld;
  assign adv     = !out_vld || bus.out_ready;
  assign ovf     = ctl_q[LAST].cmsb ^ ctl_q[LAST].cry;
  assign pos_ovf = !a_q[LAST][WIDTH-1] && !b_q[LAST][WIDTH-1];
  assign sum_sat = (ctl_q[LAST].sat && ovf) ? (pos_ovf ? SMAX : SMIN) : res_q[LAST];

  // Results are qualified by out_valid so bubbles and reset read as all-zero.
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_vld;
  assign bus.sum       = out_vld ? sum_sat : '0;
  assign bus.c_out     = out_vld && (ctl_q[LAST].cry ^ ctl_q[LAST].sel);
  assign bus.over_flow = out_vld && ovf;
  assign bus.zero      = out_vld && (sum_sat == '0);
endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe at 8/4 and 32/8: directed vectors, stall, mid-stream reset, random stream.
module tb_addsub_pipe;
  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } res_t;

  typedef struct {
    int          cfg;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sel;
    logic        sat;
    logic [31:0] es;
    logic        eco;
    logic        eov;
    logic        ez;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  int          cur;
  logic        t_valid, t_ordy, t_ci, t_sel, t_sat;
  logic [31:0] t_a, t_b;
  int          checks, errors;

  addsub_if #(.WIDTH(8))  if8  ();
  addsub_if #(.WIDTH(32)) if32 ();

  assign if8.in_valid   = t_valid && (cur == 0);
  assign if8.a          = t_a[7:0];
  assign if8.b          = t_b[7:0];
  assign if8.c_in       = t_ci;
  assign if8.sel        = t_sel;
  assign if8.sat        = t_sat;
  assign if8.out_ready  = t_ordy;
  assign if32.in_valid  = t_valid && (cur == 1);
  assign if32.a         = t_a;
  assign if32.b         = t_b;
  assign if32.c_in      = t_ci;
  assign if32.sel       = t_sel;
  assign if32.sat       = t_sat;
  assign if32.out_ready = t_ordy;

  addsub_pipe #(.WIDTH(8),  .CHUNK(4)) dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  addsub_pipe #(.WIDTH(32), .CHUNK(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

  logic        o_valid, o_rdy, o_co, o_ov, o_z;
  logic [31:0] o_sum;
  always_comb begin
    if (cur == 0) begin
      o_valid = if8.out_valid;  o_rdy = if8.in_ready;  o_sum = {24'h0, if8.sum};
      o_co    = if8.c_out;      o_ov  = if8.over_flow; o_z   = if8.zero;
    end else begin
      o_valid = if32.out_valid; o_rdy = if32.in_ready; o_sum = if32.sum;
      o_co    = if32.c_out;     o_ov  = if32.over_flow; o_z  = if32.zero;
    end
  end

  function automatic int width_of();
    return (cur == 1) ? 32 : 8;
  endfunction

  function automatic int lat_of();
    return (cur == 1) ? 4 : 2;
  endfunction

  // Reference: signed/unsigned integer arithmetic on the operand values.
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sel, input logic sat);
    res_t   r;
    longint ua, ub, sa, sb, c, full, mx, mn, mask;
    mask = (longint'(1) << w) - 1;
    mx   = mask >> 1;
    mn   = -mx - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    c    = longint'(ci);
    sa   = (ua > mx) ? ua - (mask + 1) : ua;
    sb   = (ub > mx) ? ub - (mask + 1) : ub;
    if (!sel) begin
      r.co = (ua + ub + c) > mask;
      full = sa + sb + c;
    end else begin
      r.co = ua < (ub + c);
      full = sa - sb - c;
    end
    r.ov = (full > mx) || (full < mn);
    if (sat && r.ov) full = (full > mx) ? mx : mn;
    r.s = 32'(full & mask);
    r.z = (r.s == 32'h0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg=%0d: got %0h expected %0h", name, cur, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    cur = v.cfg; t_a = v.a; t_b = v.b; t_ci = v.ci; t_sel = v.sel; t_sat = v.sat;
    t_valid = 1'b1; t_ordy = 1'b1;
    #1;
    chk("vec_in_ready", 32'(o_rdy), 32'd1);
    step();
    t_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("vec_latency", 32'(lat), 32'(lat_of()));
    chk("vec_sum", o_sum, v.es);
    chk("vec_c_out", 32'(o_co), 32'(v.eco));
    chk("vec_over_flow", 32'(o_ov), 32'(v.eov));
    chk("vec_zero", 32'(o_z), 32'(v.ez));
    step();
  endtask

  task automatic stream(input int n, input bit rnd);
    res_t        q[$];
    res_t        e;
    int          sent, got, stall_left;
    bit          stalled_once, prev_hold;
    logic [31:0] prev_sum;
    logic        prev_co, prev_ov;
    sent = 0; got = 0; stall_left = 0; stalled_once = 0; prev_hold = 0;
    prev_sum = '0; prev_co = 1'b0; prev_ov = 1'b0;
    for (int cyc = 0; cyc < 5000 && got < n; cyc++) begin
      if (prev_hold) begin
        chk("hold_valid", 32'(o_valid), 32'd1);
        chk("hold_sum", o_sum, prev_sum);
        chk("hold_flags", {30'h0, o_co, o_ov}, {30'h0, prev_co, prev_ov});
      end
      if (!rnd && o_valid && !stalled_once) begin
        stalled_once = 1;
        stall_left   = 3;
      end
      t_ordy = rnd ? ($urandom_range(0, 3) != 0) : (stall_left == 0);
      if (sent < n && (!rnd || $urandom_range(0, 4) != 0)) begin
        t_valid = 1'b1;
        t_a = $urandom; t_b = $urandom;
        t_ci = 1'($urandom); t_sel = 1'($urandom); t_sat = 1'($urandom);
      end else begin
        t_valid = 1'b0;
      end
      #1;
      if (o_valid && !t_ordy) chk("in_ready_stalled", 32'(o_rdy), 32'd0);
      if (t_valid && o_rdy) begin
        q.push_back(model(width_of(), t_a, t_b, t_ci, t_sel, t_sat));
        sent++;
      end
      if (o_valid && t_ordy) begin
        chk("out_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("str_sum", o_sum, e.s);
          chk("str_flags", {29'h0, o_co, o_ov, o_z}, {29'h0, e.co, e.ov, e.z});
        end
        got++;
      end
      prev_hold = o_valid && !t_ordy;
      prev_sum  = o_sum; prev_co = o_co; prev_ov = o_ov;
      step();
      if (stall_left > 0) stall_left--;
    end
    t_valid = 1'b0; t_ordy = 1'b1;
    chk("beats_out", 32'(got), 32'(n));
    chk("queue_empty", 32'(q.size()), 32'd0);
    repeat (6) step();
    chk("no_extra_out", 32'(o_valid), 32'd0);
  endtask

  task automatic reset_mid(input vec_t fresh);
    int ghost;
    cur = fresh.cfg;
    t_ordy = 1'b0; t_valid = 1'b1;
    t_a = 32'h11; t_b = 32'h22; t_ci = 1'b0; t_sel = 1'b0; t_sat = 1'b0;
    step();
    t_a = 32'h33; t_b = 32'h44;
    step();
    t_valid = 1'b0;
    rst_n = 1'b0;
    step();
    chk("rst_out_valid", 32'(o_valid), 32'd0);
    chk("rst_sum", o_sum, 32'h0);
    rst_n = 1'b1; t_ordy = 1'b1;
    #1;
    chk("rst_in_ready", 32'(o_rdy), 32'd1);
    ghost = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_valid) ghost++;
      step();
    end
    chk("rst_no_ghost", 32'(ghost), 32'd0);
    run_vec(fresh);
  endtask

  vec_t vecs[12];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{0, 32'h7F, 32'h01, 1'b0, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{0, 32'h7F, 32'h01, 1'b0, 1'b0, 1'b1, 32'h7F, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{0, 32'h00, 32'h01, 1'b0, 1'b1, 1'b0, 32'hFF, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{0, 32'h80, 32'h01, 1'b0, 1'b1, 1'b0, 32'h7F, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{0, 32'h80, 32'h01, 1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{0, 32'hFF, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1, 32'h0, 32'h1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1, 32'h80000000, 32'h1, 1'b0, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1, 32'h80000000, 32'h1, 1'b0, 1'b1, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1};

    checks = 0; errors = 0;
    cur = 0; rst_n = 1'b0;
    t_valid = 1'b0; t_ordy = 1'b1; t_ci = 1'b0; t_sel = 1'b0; t_sat = 1'b0;
    t_a = '0; t_b = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      cur = c;
      #1;
      chk("reset_out_valid", 32'(o_valid), 32'd0);
      chk("reset_sum", o_sum, 32'h0);
      chk("reset_flags", {29'h0, o_co, o_ov, o_z}, 32'h0);
      chk("reset_in_ready", 32'(o_rdy), 32'd1);
    end
    step();
    rst_n = 1'b1;
    step();

    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 12; i++) begin
        if (vecs[i].cfg == c) run_vec(vecs[i]);
      end
      cur = c;
      stream(4, 1'b0);
      reset_mid(vecs[c * 6 + 5]);
      cur = c;
      stream(150, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
